// File: rtl/intc_pkg.sv
// Shared definitions for the priority interrupt controller: FSM state
// encoding, IO register offsets and the spurious vector value.
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADR_PEND = 2'd0;
    localparam logic [1:0] ADR_MASK = 2'd1;
    localparam logic [1:0] ADR_VEC  = 2'd2;
    localparam logic [1:0] ADR_EOI  = 2'd3;

    // Vector value meaning "nothing in service"; sliced down to VEC_W bits.
    localparam logic [15:0] SPURIOUS = 16'hFFFF;

endpackage

// File: rtl/intr_controller_if.sv
// IO bus between the MCU and the interrupt controller register block.
// master = MCU side (drives strobes/address/data), slave = controller.
interface intr_controller_if;
    logic        io_cs;
    logic        io_wr;
    logic        io_rd;
    logic [1:0]  io_addr;
    logic [31:0] io_din;
    logic [31:0] io_dout;

    modport master (output io_cs, io_wr, io_rd, io_addr, io_din, input io_dout);
    modport slave  (input io_cs, io_wr, io_rd, io_addr, io_din, output io_dout);
endinterface

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder. idx is only meaningful when valid.
module intc_prio_enc #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_controller.sv
// Priority interrupt controller in front of the MCU's intr/int_ack pair.
// Rising edges on irq_src latch into PENDING; the lowest-index pending and
// enabled source is presented as intr. Registers: PENDING (W1C), MASK,
// VECTOR (RO), EOI (WO).
// Optional build macro INTC_AUTO_EOI_EN: the ack itself ends service, so
// there is no SERVICE state and EOI writes have no effect.
module intr_controller
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int VEC_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               int_ack,
    output logic               intr,
    intr_controller_if.slave   bus
);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [VEC_W-1:0]   vector_q, vector_d;
    logic               intr_q, intr_d;

    logic [NUM_SRC-1:0] irq_edge;
    logic [NUM_SRC-1:0] eligible;
    logic               win_vld;
    logic [VEC_W-1:0]   win_idx;
    logic               wr_pend, wr_mask, wr_eoi;
    logic               ack_take;
    logic               unused_din;

    assign irq_edge = irq_src & ~irq_prev_q;
    assign eligible = pending_q & mask_q;

    assign wr_pend = bus.io_cs & bus.io_wr & (bus.io_addr == ADR_PEND);
    assign wr_mask = bus.io_cs & bus.io_wr & (bus.io_addr == ADR_MASK);
    assign wr_eoi  = bus.io_cs & bus.io_wr & (bus.io_addr == ADR_EOI);

    // Only the low NUM_SRC bits of write data carry meaning.
    assign unused_din = ^bus.io_din[31:NUM_SRC];

    intc_prio_enc #(
        .N (NUM_SRC),
        .W (VEC_W)
    ) u_prio_enc (
        .req   (eligible),
        .valid (win_vld),
        .idx   (win_idx)
    );

    // An ack only counts while a request is actually being presented.
    assign ack_take = (state_q == ST_ASSERT) & int_ack & win_vld;

    // FSM next state; intr follows the ASSERT state one cycle late and drops
    // together with the state leaving ASSERT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (ack_take) begin
`ifdef INTC_AUTO_EOI_EN
                    state_d = ST_IDLE;
`else
                    state_d = ST_SERVICE;
`endif
                end else if (!win_vld) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
`ifdef INTC_AUTO_EOI_EN
                state_d = ST_IDLE;
`else
                if (wr_eoi) state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        intr_d = (state_q == ST_ASSERT) && (state_d == ST_ASSERT);
    end

    // Register updates: edge capture, W1C, mask writes, vector capture on ack.
    // New edges are OR-ed last so a set beats a same-cycle clear.
    always_comb begin
        irq_prev_d = irq_src;
        pending_d  = pending_q;
        mask_d     = mask_q;
        vector_d   = vector_q;
        if (wr_pend) pending_d = pending_d & ~bus.io_din[NUM_SRC-1:0];
        if (wr_mask) mask_d = bus.io_din[NUM_SRC-1:0];
        if (ack_take) begin
            vector_d  = win_idx;
            pending_d = pending_d & ~(NUM_SRC'(1) << win_idx);
        end
        pending_d = pending_d | irq_edge;
    end

    // Read mux; reads have no side effects.
    always_comb begin
        bus.io_dout = 32'h0;
        if (bus.io_cs && bus.io_rd) begin
            case (bus.io_addr)
                ADR_PEND: bus.io_dout = {{(32-NUM_SRC){1'b0}}, pending_q};
                ADR_MASK: bus.io_dout = {{(32-NUM_SRC){1'b0}}, mask_q};
                ADR_VEC:  bus.io_dout = {{(32-VEC_W){1'b0}}, vector_q};
                default:  bus.io_dout = 32'h0;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            vector_q   <= SPURIOUS[VEC_W-1:0];
            intr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            vector_q   <= vector_d;
            intr_q     <= intr_d;
        end
    end

    assign intr = intr_q;

endmodule
